// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
// Module      : traffic_pkg
// Description : Mode encodings, state codes, default durations and output
//               decode shared by the traffic-light phase sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    localparam logic [1:0] MODE_RED    = 2'b00;
    localparam logic [1:0] MODE_GREEN  = 2'b01;
    localparam logic [1:0] MODE_YELLOW = 2'b10;
    localparam logic [1:0] MODE_FLASH  = 2'b11;

    typedef enum logic [2:0] {
        ALLRED_A  = 3'd0,
        NS_GREEN  = 3'd1,
        NS_YELLOW = 3'd2,
        ALLRED_B  = 3'd3,
        EW_GREEN  = 3'd4,
        EW_YELLOW = 3'd5,
        FLASH     = 3'd6
    } state_t;

    localparam int DEF_GREEN_MIN   = 16;
    localparam int DEF_GREEN_MAX   = 48;
    localparam int DEF_YELLOW_TIME = 4;
    localparam int DEF_ALLRED_TIME = 2;
    localparam int DEF_TW          = 8;

    function automatic logic [1:0] ns_mode(input state_t s);
        case (s)
            NS_GREEN:  ns_mode = MODE_GREEN;
            NS_YELLOW: ns_mode = MODE_YELLOW;
            FLASH:     ns_mode = MODE_FLASH;
            default:   ns_mode = MODE_RED;
        endcase
    endfunction

    function automatic logic [1:0] ew_mode(input state_t s);
        case (s)
            EW_GREEN:  ew_mode = MODE_GREEN;
            EW_YELLOW: ew_mode = MODE_YELLOW;
            FLASH:     ew_mode = MODE_FLASH;
            default:   ew_mode = MODE_RED;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/traffic_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : traffic_sequencer_if
// Description : Sensor/override inputs and light mode outputs of the sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
interface traffic_sequencer_if;

    logic       carNS;
    logic       carEW;
    logic       flashReq;
    logic [1:0] lightNorthSouth;
    logic [1:0] lightEastWest;
    logic [2:0] phase;

    modport master (
        output carNS, carEW, flashReq,
        input  lightNorthSouth, lightEastWest, phase
    );

    modport slave (
        input  carNS, carEW, flashReq,
        output lightNorthSouth, lightEastWest, phase
    );

endinterface
`default_nettype wire

// File: rtl/traffic_sequencer_phase_timer.sv
`default_nettype none
// ============================================================================
// Module      : phase_timer
// Description : TW-bit saturating up-counter with synchronous clear.
// Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int TW = 8
) (
    input  wire logic          clk_i,
    input  wire logic          rst_ni,
    input  wire logic          clr_i,
    output logic [TW-1:0]      t_o
);

    logic [TW-1:0] cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (cnt_q != {TW{1'b1}}) begin
            cnt_q <= cnt_q + TW'(1);
        end
    end

    assign t_o = cnt_q;

endmodule
`default_nettype wire

// File: rtl/traffic_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : traffic_sequencer
// Description : Two-approach NS/EW phase sequencer with demand-actuated green,
//               yellow and all-red clearance, and flash override.
// Revision    : 1.0 - initial release
// ============================================================================
module traffic_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN   = DEF_GREEN_MIN,
    parameter int GREEN_MAX   = DEF_GREEN_MAX,
    parameter int YELLOW_TIME = DEF_YELLOW_TIME,
    parameter int ALLRED_TIME = DEF_ALLRED_TIME,
    parameter int TW          = DEF_TW
) (
    input  wire logic            Clock,
    input  wire logic            reset,
    traffic_sequencer_if.slave   bus
);

    localparam int C_T_MAX = (2 ** TW) - 1;

    if (GREEN_MIN < 1) begin : g_chk_gmin
        $fatal(1, "GREEN_MIN must be at least 1");
    end
    if (GREEN_MAX < GREEN_MIN) begin : g_chk_gmax
        $fatal(1, "GREEN_MAX must not be below GREEN_MIN");
    end
    if (YELLOW_TIME < 1 || ALLRED_TIME < 1) begin : g_chk_clear
        $fatal(1, "YELLOW_TIME and ALLRED_TIME must be at least 1");
    end
    if (GREEN_MAX > C_T_MAX || YELLOW_TIME > C_T_MAX || ALLRED_TIME > C_T_MAX) begin : g_chk_tw
        $fatal(1, "durations exceed timer range");
    end

    localparam logic [TW-1:0] C_GMIN_LAST = TW'(GREEN_MIN - 1);
    localparam logic [TW-1:0] C_GMAX_LAST = TW'(GREEN_MAX - 1);
    localparam logic [TW-1:0] C_Y_LAST    = TW'(YELLOW_TIME - 1);
    localparam logic [TW-1:0] C_AR_LAST   = TW'(ALLRED_TIME - 1);

    state_t        state_q, state_d;
    logic          pend_ns_q, pend_ns_d;
    logic          pend_ew_q, pend_ew_d;
    logic [1:0]    ns_mode_q, ew_mode_q;
    logic [TW-1:0] t;
    logic          timer_clr;

    phase_timer #(.TW(TW)) u_phase_timer (
        .clk_i  (Clock),
        .rst_ni (reset),
        .clr_i  (timer_clr),
        .t_o    (t)
    );

    // A green yields only to waiting opposing demand; own demand holds it until GREEN_MAX.
    always_comb begin
        state_d = state_q;
        if (bus.flashReq) begin
            state_d = FLASH;
        end else begin
            case (state_q)
                FLASH:     state_d = ALLRED_B;
                ALLRED_B:  if (t == C_AR_LAST) state_d = NS_GREEN;
                NS_GREEN:  if (t >= C_GMIN_LAST && pend_ew_q &&
                               (!bus.carNS || t >= C_GMAX_LAST)) state_d = NS_YELLOW;
                NS_YELLOW: if (t == C_Y_LAST)  state_d = ALLRED_A;
                ALLRED_A:  if (t == C_AR_LAST) state_d = EW_GREEN;
                EW_GREEN:  if (t >= C_GMIN_LAST && pend_ns_q &&
                               (!bus.carEW || t >= C_GMAX_LAST)) state_d = EW_YELLOW;
                EW_YELLOW: if (t == C_Y_LAST)  state_d = ALLRED_B;
                default:   state_d = ALLRED_B;
            endcase
        end
    end

    assign timer_clr = (state_d != state_q);

    // Entering green discards that direction's same-cycle sensor sample.
    assign pend_ns_d = (state_d == NS_GREEN && state_q != NS_GREEN) ? 1'b0 : (pend_ns_q | bus.carNS);
    assign pend_ew_d = (state_d == EW_GREEN && state_q != EW_GREEN) ? 1'b0 : (pend_ew_q | bus.carEW);

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            state_q   <= ALLRED_B;
            pend_ns_q <= 1'b0;
            pend_ew_q <= 1'b0;
            ns_mode_q <= MODE_RED;
            ew_mode_q <= MODE_RED;
        end else begin
            state_q   <= state_d;
            pend_ns_q <= pend_ns_d;
            pend_ew_q <= pend_ew_d;
            ns_mode_q <= ns_mode(state_d);
            ew_mode_q <= ew_mode(state_d);
        end
    end

    assign bus.lightNorthSouth = ns_mode_q;
    assign bus.lightEastWest   = ew_mode_q;
    assign bus.phase           = state_q;

endmodule
`default_nettype wire
